// File: rtl/rom_burst_arbiter_pkg.sv
// rom_burst_arbiter_pkg
//   Shared constants for the ROM burst arbiter slice.
//   ADDR_W/DATA_W size the 16x8 ROM port. LEN_W sizes the burst length field (0..31).
//   MAX_LEN is the longest burst actually walked. Longer requests are clamped to it.
//   The state encoding is kept as plain constants so that it stays compatible with the legacy decode.
package rom_burst_arbiter_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 5;

    localparam logic [LEN_W-1:0] MAX_LEN = 5'd16;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_BURST = 1'b1;

    // Any request longer than the ROM depth is cut down to one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// rom_burst_arbiter_if
//   Groups the signals between the two requesters, the ROM and the arbiter.
//   The slave modport is the arbiter's side.
//   The master modport is the side that holds the requesters and the ROM.
//     req0/addr0/len0, req1/addr1/len1 : burst requests (level) with start address and word count
//     gnt0/gnt1                        : one-cycle accept pulses
//     rom_addr/rom_data                : ROM read port (rom_data is combinational)
//     data_out/valid/owner/done/busy   : registered read stream and status
interface rom_burst_arbiter_if;
    import rom_burst_arbiter_pkg::*;

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [LEN_W-1:0]  len0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [LEN_W-1:0]  len1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              owner;
    logic              done;
    logic              busy;

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1, rom_data,
        output gnt0, gnt1, rom_addr, data_out, valid, owner, done, busy
    );

    modport master (
        output req0, addr0, len0, req1, addr1, len1, rom_data,
        input  gnt0, gnt1, rom_addr, data_out, valid, owner, done, busy
    );

endinterface

// File: rtl/rom_burst_arbiter_rr.sv
// rr_arbiter2
//   Two-input round-robin picker.
//   gnt is a combinational one-hot choice among the active requests.
//   When both requests are active, the requester that did not win last time is chosen.
//   rr_last records the winner on cycles where update is high and a request is present.
//   It resets to 1, so requester 0 wins the first tie.
//     clk, rst : clock, asynchronous active-high reset
//     req[1:0] : request levels
//     update   : commit the current pick into rr_last
//     gnt[1:0] : one-hot pick (zero when no request is active)
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic rr_last;

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            rr_last <= gnt[1];
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Sequences burst reads from an external 16x8 asynchronous-read ROM.
//   The ROM's single port is shared between two requesters by round-robin.
//   A granted burst walks the ROM one address per cycle from the latched start address.
//   The walk wraps from 15 to 0.
//   Each word is returned registered on data_out with valid, tagged by owner.
//   done marks the last word. A zero-length request pulses gnt and done together and produces no data.
//     clk  : clock
//     rst  : asynchronous active-high reset
//     bus  : rom_burst_arbiter_if.slave (requests, grants, ROM port, read stream, status)
module rom_burst_arbiter
    import rom_burst_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rom_burst_arbiter_if.slave   bus
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  win_len;
    logic [ADDR_W-1:0] win_addr;
    logic [1:0]        pick;
    logic              arb_en;
    logic              take;

    logic              gnt0_r;
    logic              gnt1_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              owner_r;
    logic              done_r;

    // No arbitration happens in the IDLE cycle that carries done.
    // This holds the next grant until T+2+len, both after a burst and after a zero-length request.
    assign arb_en = (state == ST_IDLE) && !done_r;
    assign take   = arb_en && (pick != 2'b00);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.req1, bus.req0}),
        .update (arb_en),
        .gnt    (pick)
    );

    always_comb begin
        win_addr = pick[1] ? bus.addr1 : bus.addr0;
        win_len  = clamp_len(pick[1] ? bus.len1 : bus.len0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            owner_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        gnt0_r    <= pick[0];
                        gnt1_r    <= pick[1];
                        owner_r   <= pick[1];
                        cur_addr  <= win_addr;
                        remaining <= win_len;
                        if (win_len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    data_r    <= bus.rom_data;
                    valid_r   <= 1'b1;
                    cur_addr  <= cur_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == 5'd1) begin
                        done_r <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_addr = (state == ST_BURST) ? cur_addr : '0;
    assign bus.busy     = (state == ST_BURST);
    assign bus.gnt0     = gnt0_r;
    assign bus.gnt1     = gnt1_r;
    assign bus.data_out = data_r;
    assign bus.valid    = valid_r;
    assign bus.owner    = owner_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter
//   Drives directed and random burst requests into rom_burst_arbiter with a behavioural ROM attached.
//   Every cycle's outputs are compared against a transaction-level schedule.
//   The schedule is built from the latency rules: grant at T+1, beats T+2..T+1+len, done on the last beat,
//   and the next arbitration at T+2+len.
module tb_rom_burst_arbiter;

    localparam int MAXC = 2048;

    logic clk;
    logic rst;

    rom_burst_arbiter_if bus ();

    rom_burst_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] rom_img [16];

    always_comb bus.rom_data = rom_img[bus.rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected schedule, indexed by cycle number.
    logic       e_gnt0  [MAXC];
    logic       e_gnt1  [MAXC];
    logic       e_valid [MAXC];
    logic       e_done  [MAXC];
    logic       e_busy  [MAXC];
    logic       e_oset  [MAXC];
    logic       e_oval  [MAXC];
    logic [7:0] e_data  [MAXC];
    logic [3:0] e_raddr [MAXC];

    int   c;
    int   next_arb;
    logic m_rr_last;
    logic [7:0] m_data;
    logic m_owner;

    int tests_run;
    int tests_failed;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, c, act, exp);
        end
    endtask

    task automatic clear_from(input int from);
        for (int i = from; i < MAXC; i++) begin
            e_gnt0[i] = 1'b0; e_gnt1[i] = 1'b0; e_valid[i] = 1'b0; e_done[i] = 1'b0;
            e_busy[i] = 1'b0; e_oset[i] = 1'b0; e_oval[i] = 1'b0;
            e_data[i] = 8'h00; e_raddr[i] = 4'h0;
        end
    endtask

    task automatic check_cycle();
        if (e_valid[c]) m_data = e_data[c];
        if (e_oset[c]) m_owner = e_oval[c];
        check_eq("gnt0",     {31'b0, bus.gnt0},  {31'b0, e_gnt0[c]});
        check_eq("gnt1",     {31'b0, bus.gnt1},  {31'b0, e_gnt1[c]});
        check_eq("valid",    {31'b0, bus.valid}, {31'b0, e_valid[c]});
        check_eq("done",     {31'b0, bus.done},  {31'b0, e_done[c]});
        check_eq("busy",     {31'b0, bus.busy},  {31'b0, e_busy[c]});
        check_eq("owner",    {31'b0, bus.owner}, {31'b0, m_owner});
        check_eq("data_out", {24'b0, bus.data_out}, {24'b0, m_data});
        check_eq("rom_addr", {28'b0, bus.rom_addr}, {28'b0, e_raddr[c]});
    endtask

    // Reference model: decides what the request seen in cycle c leads to and books it into the schedule.
    task automatic model_cycle(input logic r0, input logic [3:0] a0, input logic [4:0] l0,
                               input logic r1, input logic [3:0] a1, input logic [4:0] l1);
        int w;
        int a;
        int len;
        if (c < next_arb || !(r0 || r1)) return;
        if (r0 && !r1)      w = 0;
        else if (r1 && !r0) w = 1;
        else                w = m_rr_last ? 0 : 1;
        m_rr_last = (w == 1);
        a   = (w == 1) ? int'(a1) : int'(a0);
        len = (w == 1) ? int'(l1) : int'(l0);
        if (len > 16) len = 16;
        if (w == 1) e_gnt1[c+1] = 1'b1; else e_gnt0[c+1] = 1'b1;
        e_oset[c+1] = 1'b1;
        e_oval[c+1] = (w == 1);
        if (len == 0) begin
            e_done[c+1] = 1'b1;
        end else begin
            for (int k = 0; k < len; k++) begin
                e_busy[c+1+k]  = 1'b1;
                e_raddr[c+1+k] = 4'((a + k) % 16);
                e_valid[c+2+k] = 1'b1;
                e_data[c+2+k]  = rom_img[(a + k) % 16];
            end
            e_done[c+1+len] = 1'b1;
        end
        next_arb = c + 2 + len;
    endtask

    task automatic drive(input logic r0, input logic [3:0] a0, input logic [4:0] l0,
                         input logic r1, input logic [3:0] a1, input logic [4:0] l1);
        bus.req0 = r0; bus.addr0 = a0; bus.len0 = l0;
        bus.req1 = r1; bus.addr1 = a1; bus.len1 = l1;
        model_cycle(r0, a0, l0, r1, a1, l1);
        @(negedge clk);
        c++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 5'd0, 1'b0, 4'h0, 5'd0);
    endtask

    // Reset is asserted between edges; the outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        clear_from(c);
        m_data    = 8'h00;
        m_owner   = 1'b0;
        m_rr_last = 1'b1;
        check_cycle();
        @(negedge clk);
        c++;
        check_cycle();
        rst = 1'b0;
        next_arb = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", c);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] img [16];
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22,
                8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00};
        for (int i = 0; i < 16; i++) rom_img[i] = img[i];

        tests_run = 0;
        tests_failed = 0;
        c = 0;
        next_arb = 0;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0;
        do_reset();

        // Single requester, in-range burst.
        drive(1'b1, 4'd2, 5'd3, 1'b0, 4'd0, 5'd0);
        idle(6);
        // Requester 1, burst wrapping past address 15.
        drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd14, 5'd4);
        idle(7);
        // Tie right after reset: requester 0 first, then requester 1 after the gap.
        do_reset();
        drive(1'b1, 4'd0, 5'd2, 1'b1, 4'd8, 5'd2);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd8, 5'd2);
        idle(6);
        // Zero-length request, then an over-long request clamped to 16 beats.
        drive(1'b1, 4'd7, 5'd0, 1'b0, 4'd0, 5'd0);
        idle(3);
        drive(1'b1, 4'd3, 5'd20, 1'b0, 4'd0, 5'd0);
        idle(20);
        // Reset in the middle of a burst, then a tie must favour requester 0.
        drive(1'b1, 4'd5, 5'd8, 1'b0, 4'd0, 5'd0);
        idle(3);
        do_reset();
        drive(1'b1, 4'd1, 5'd1, 1'b1, 4'd9, 5'd1);
        idle(5);
        // req0 held while req1 pulses mid-burst; at the next tie requester 1 wins.
        drive(1'b1, 4'd0, 5'd4, 1'b0, 4'd0, 5'd0);
        for (int i = 1; i <= 8; i++)
            drive(1'b1, 4'd0, 5'd4, (i == 2) || (i >= 5), 4'd10, 5'd3);
        idle(25);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                      $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            end
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
